// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL lock reset sequencer.
// Holds the sequencer state encoding, the loss counter width and a small sizing helper.
package pll_reset_pkg;

    localparam int LOSS_COUNT_W = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        REL_SDRAM,
        WAIT_SDRAM,
        REL_DECODE,
        RUN
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer that brings an asynchronous level into the local clock domain.
// Flops clear to 0 on the asynchronous active-low reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Releases SDRAM, decode and CPU resets in order once the PLL lock has been stable long enough.
// Define LOCK_LOSS_COUNTER_EN to build the saturating lock-loss counter; otherwise loss_count is tied to 0.
module pll_lock_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic                    clkSYSTEM,
    input  logic                    resetn,
    input  logic                    locked,
    input  logic                    sdram_ready,
    output logic                    rst_sdram_n,
    output logic                    rst_decode_n,
    output logic                    rst_cpu_n,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [LOSS_COUNT_W-1:0] loss_count
);

    localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, STAGGER_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES);

    logic       lock_s;
    seq_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic rst_sdram_n_q, rst_sdram_n_d;
    logic rst_decode_n_q, rst_decode_n_d;
    logic rst_cpu_n_q, rst_cpu_n_d;
    logic ready_q, ready_d;
    logic lock_lost_q, lock_lost_d;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clkSYSTEM),
        .rst_n(resetn),
        .d    (locked),
        .q    (lock_s)
    );

    always_ff @(posedge clkSYSTEM or negedge resetn) begin
        if (!resetn) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A lost lock overrides every other transition, including terminal counts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = REL_SDRAM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REL_SDRAM: begin
                    state_d = WAIT_SDRAM;
                end
                WAIT_SDRAM: begin
                    if (sdram_ready) begin
                        state_d = REL_DECODE;
                        cnt_d   = '0;
                    end
                end
                REL_DECODE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gating with lock_s pulls every reset low on the same edge the FSM falls back.
    always_comb begin
        rst_sdram_n_d  = lock_s && (state_q inside {REL_SDRAM, WAIT_SDRAM, REL_DECODE, RUN});
        rst_decode_n_d = lock_s && (state_q inside {REL_DECODE, RUN});
        rst_cpu_n_d    = lock_s && (state_q == RUN);
        ready_d        = lock_s && (state_q == RUN);
        lock_lost_d    = !lock_s && (state_q != WAIT_LOCK);
    end

    always_ff @(posedge clkSYSTEM or negedge resetn) begin
        if (!resetn) begin
            rst_sdram_n_q  <= 1'b0;
            rst_decode_n_q <= 1'b0;
            rst_cpu_n_q    <= 1'b0;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b0;
        end else begin
            rst_sdram_n_q  <= rst_sdram_n_d;
            rst_decode_n_q <= rst_decode_n_d;
            rst_cpu_n_q    <= rst_cpu_n_d;
            ready_q        <= ready_d;
            lock_lost_q    <= lock_lost_d;
        end
    end

    assign rst_sdram_n  = rst_sdram_n_q;
    assign rst_decode_n = rst_decode_n_q;
    assign rst_cpu_n    = rst_cpu_n_q;
    assign ready        = ready_q;
    assign lock_lost    = lock_lost_q;

`ifdef LOCK_LOSS_COUNTER_EN
    logic [LOSS_COUNT_W-1:0] loss_count_q, loss_count_d;

    always_comb begin
        loss_count_d = loss_count_q;
        if (lock_lost_d && (loss_count_q != '1)) begin
            loss_count_d = loss_count_q + LOSS_COUNT_W'(1);
        end
    end

    always_ff @(posedge clkSYSTEM or negedge resetn) begin
        if (!resetn) begin
            loss_count_q <= '0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: doc/pll_lock_reset_sequencer.md
PLL_LOCK_RESET_SEQUENCER -- requirements
Module: pll_lock_reset_sequencer

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on locked (minimum 2).
REQ-002 The module SHALL have parameter STABLE_CYCLES, default 1024, giving the consecutive synced-lock cycles required before any release (minimum 1).
REQ-003 The module SHALL have parameter STAGGER_CYCLES, default 16, giving the gap between successive reset releases (minimum 1).
REQ-004 The module SHALL have port clkSYSTEM, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port resetn, input, width 1: reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port locked, input, width 1: PLL lock, asynchronous to clkSYSTEM.
REQ-007 The module SHALL have port sdram_ready, input, width 1: SDRAM controller init-done handshake, synchronous.
REQ-008 The module SHALL have port rst_sdram_n, output, width 1: active-low reset to the SDRAM controller domain.
REQ-009 The module SHALL have port rst_decode_n, output, width 1: active-low reset to the instruction expander.
REQ-010 The module SHALL have port rst_cpu_n, output, width 1: active-low reset to the CPU and I/O.
REQ-011 The module SHALL have port ready, output, width 1: high only in state RUN.
REQ-012 The module SHALL have port lock_lost, output, width 1: one-cycle pulse on a lock drop.
REQ-013 The module SHALL have port loss_count, output, width 8: saturating lock-loss count (see Configuration).

Function
REQ-014 locked SHALL pass through SYNC_STAGES flops to form lock_s; no other logic SHALL sample locked.
REQ-015 The FSM SHALL have states WAIT_LOCK, STABLE, REL_SDRAM, WAIT_SDRAM, REL_DECODE and RUN.
REQ-016 From WAIT_LOCK, lock_s=1 SHALL move to STABLE with the counter cleared.
REQ-017 In STABLE, the counter SHALL increment each cycle, and reaching STABLE_CYCLES-1 SHALL move to REL_SDRAM.
REQ-018 REL_SDRAM SHALL deassert rst_sdram_n and move to WAIT_SDRAM on the next edge.
REQ-019 WAIT_SDRAM SHALL hold, with no timeout, until sdram_ready=1, then move to REL_DECODE with the counter cleared.
REQ-020 REL_DECODE SHALL deassert rst_decode_n, count STAGGER_CYCLES, then move to RUN.
REQ-021 RUN SHALL deassert rst_cpu_n and assert ready.
REQ-022 Outputs SHALL be registered: each reset rises on the first edge after its state is entered and stays high in all later states.
REQ-023 lock_s=0 in any state except WAIT_LOCK SHALL return the FSM to WAIT_LOCK on the next edge and drive all three resets low on that same edge.
REQ-024 lock_s=0 SHALL take priority over every other transition, including simultaneous sdram_ready or counter terminal count.
REQ-025 lock_lost SHALL pulse for one cycle on the edge where the FSM leaves a non-WAIT_LOCK state due to lock_s=0; a drop during STABLE SHALL also pulse.
REQ-026 Glitches of locked shorter than one cycle that are not captured SHALL have no effect; any captured low SHALL restart the full sequence.
REQ-027 sdram_ready SHALL be ignored in every state except WAIT_SDRAM.
REQ-028 The counter SHALL be sized $clog2 of the larger of STABLE_CYCLES and STAGGER_CYCLES, plus 1, and SHALL never wrap.

Reset
REQ-029 resetn=0 SHALL asynchronously force: FSM to WAIT_LOCK, synchronizer flops to 0, counter to 0, all resets to 0, ready=0, lock_lost=0, loss_count=0.
REQ-030 Reset release SHALL begin the sequence from WAIT_LOCK; outputs SHALL not rise before the full sequence completes.

Configuration
REQ-031 With LOCK_LOSS_COUNTER_EN defined, loss_count SHALL increment on each lock_lost pulse and saturate at 255.
REQ-032 With LOCK_LOSS_COUNTER_EN undefined, loss_count SHALL be tied to 0, with no counter flops.

Structure
REQ-033 Package pll_reset_pkg SHALL hold the state enum (typedef seq_state_t) and the LOSS_COUNT_W=8 constant.
REQ-034 The synchronizer SHALL be sub-module sync_ff, parameterised by SYNC_STAGES, with async active-low reset.

Verification (STABLE_CYCLES=8, STAGGER_CYCLES=4, SYNC_STAGES=2)
REQ-035 Bench: locked=1 from the edge after reset release and sdram_ready tied 1 -> rst_sdram_n rises at edge 12, rst_decode_n at edge 14, rst_cpu_n and ready at edge 19.
REQ-036 Bench: sdram_ready held 0 for 50 cycles -> the FSM stays in WAIT_SDRAM with rst_decode_n=0 and rst_cpu_n=0; sdram_ready=1 -> rst_decode_n rises 2 edges later.
REQ-037 Bench: in RUN, locked dropped for 3 cycles -> 2 edges later all resets go 0, ready=0, lock_lost is a single pulse, loss_count=1; full re-sequence follows.
REQ-038 Bench: locked low on the same cycle STABLE reaches terminal count -> the FSM returns to WAIT_LOCK, rst_sdram_n stays 0, lock_lost pulses.
REQ-039 Bench: 300 lock drops with LOCK_LOSS_COUNTER_EN -> loss_count=255; without the macro -> loss_count=0 throughout.
REQ-040 Bench: resetn asserted mid REL_DECODE, asynchronous to the clock -> all outputs go 0 immediately, without waiting for an edge.
